// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. Recovers 8-bit characters from the asynchronous
//            Rx_Serial line (start bit, 8 data bits LSB first, optional even
//            parity, one stop bit). Each character is presented as a
//            one-cycle strobe with data. Bit timing comes from counting
//            CLKS_PER_BIT system clocks per bit, with sampling at mid-bit.
// Ports    : Clock         - system clock, rising edge
//            Reset         - synchronous, active-high
//            Rx_Serial     - asynchronous serial input, idles high
//            Rx_DV         - one-cycle strobe, Rx_Byte valid in this cycle
//            Rx_Byte[7:0]  - last correctly received character, held
//            Rx_Frame_Err  - one-cycle strobe, stop bit sampled low
//            Rx_Parity_Err - one-cycle strobe, even-parity mismatch
// Config   : define UART_RX_PARITY_EN to receive an even parity bit between
//            the data and the stop bit. When it is not defined the frame is
//            8N1 and Rx_Parity_Err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Rx_Serial,
    output logic       Rx_DV,
    output logic [7:0] Rx_Byte,
    output logic       Rx_Frame_Err,
    output logic       Rx_Parity_Err
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5,
        BREAK   = 3'd6
    } state_t;

    state_t           state;
    logic             sync_meta;
    logic             sync_line;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // Line idles high, so the synchronizer resets to the idle level
            // and a reset never looks like a start edge.
            sync_meta    <= 1'b1;
            sync_line    <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            Rx_DV        <= 1'b0;
            Rx_Byte      <= 8'h00;
            Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Rx_Parity_Err <= 1'b0;
            parity_bad    <= 1'b0;
`endif
        end else begin
            sync_meta <= Rx_Serial;
            sync_line <= sync_meta;

            // Strobes default low so every pulse is exactly one cycle.
            Rx_DV        <= 1'b0;
            Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Rx_Parity_Err <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (!sync_line) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= START;
                    end
                end

                // Re-check the line at the middle of the start bit; a high
                // level there means the falling edge was only a glitch.
                START: begin
                    if (cnt == C_HALF) begin
                        cnt   <= '0;
                        state <= sync_line ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // From here on each sample lands a full bit period after the
                // previous one, i.e. at the middle of every following bit.
                DATA: begin
                    if (cnt == C_BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= sync_line;
                        if (idx == 3'd7) begin
                            idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit XOR to zero.
                PARITY: begin
                    if (cnt == C_BIT_LAST) begin
                        cnt        <= '0;
                        parity_bad <= sync_line ^ (^shift);
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == C_BIT_LAST) begin
                        cnt <= '0;
                        if (sync_line) begin
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                Rx_Parity_Err <= 1'b1;
                            end else begin
                                Rx_Byte <= shift;
                                Rx_DV   <= 1'b1;
                            end
`else
                            Rx_Byte <= shift;
                            Rx_DV   <= 1'b1;
`endif
                            state <= CLEANUP;
                        end else begin
                            Rx_Frame_Err <= 1'b1;
                            state        <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leaving here half a bit before the end of the stop bit lets
                // a back-to-back start edge be seen in IDLE.
                CLEANUP: begin
                    state <= IDLE;
                end

                // A line held low after a bad stop bit must not re-trigger
                // reception; wait for it to return to idle first.
                BREAK: begin
                    if (sync_line) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign Rx_Parity_Err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at CLKS_PER_BIT = 8. Ideal frames
//            are driven bit by bit; a frame-level model predicts which strobe
//            each frame must produce, its data and when it must appear, and
//            the observed strobes are matched against that prediction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
    localparam int LAT       = 3 + HALF + 10 * CPB;
`else
    localparam bit PARITY_ON = 1'b0;
    localparam int LAT       = 3 + HALF + 9 * CPB;
`endif
    localparam int BITS_PER_FRAME = PARITY_ON ? 11 : 10;

    localparam int K_DV = 1;
    localparam int K_FE = 2;
    localparam int K_PE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_fe;
    logic       rx_pe;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .Clock         (clk),
        .Reset         (rst),
        .Rx_Serial     (rx),
        .Rx_DV         (rx_dv),
        .Rx_Byte       (rx_byte),
        .Rx_Frame_Err  (rx_fe),
        .Rx_Parity_Err (rx_pe)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Posedge count, read at negedges by both driver and monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int data;
        int t;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    logic [7:0] last_good = 8'h00;

    // Monitor: every strobe becomes an event; strobes must never coincide.
    always @(negedge clk) begin
        if (!rst && (rx_dv || rx_fe || rx_pe)) begin
            ev_t e;
            check("strobe_exclusive", int'(rx_dv) + int'(rx_fe) + int'(rx_pe), 1);
            e.kind = rx_dv ? K_DV : (rx_fe ? K_FE : K_PE);
            e.data = int'(rx_byte);
            e.t    = cyc;
            obs_q.push_back(e);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge; returns its start time.
    task automatic drive_frame(input logic [7:0] b, input logic stop_val,
                               input logic par_ok, output int t0);
        t0 = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (PARITY_ON) begin
            rx = par_ok ? (^b) : ~(^b);
            repeat (CPB) @(negedge clk);
        end
        rx = stop_val;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends a frame and records what the receiver must report for it.
    task automatic frame(input logic [7:0] b, input logic stop_ok,
                         input logic par_ok, input int extra_low);
        int  t0;
        ev_t e;
        drive_frame(b, stop_ok, par_ok, t0);
        e.t = t0 + LAT;
        if (!stop_ok) begin
            e.kind = K_FE;
            e.data = int'(last_good);
            rx = 1'b0;
            repeat (extra_low) @(negedge clk);
            idle(CPB);
        end else if (PARITY_ON && !par_ok) begin
            e.kind = K_PE;
            e.data = int'(last_good);
        end else begin
            e.kind    = K_DV;
            e.data    = int'(b);
            last_good = b;
        end
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            int d;
            check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
            d = obs_q[i].t - exp_q[i].t;
            check({tag, "_latency_offset"}, (d >= -1 && d <= 1) ? 0 : d, 0);
        end
        check({tag, "_byte_hold"}, int'(rx_byte), int'(last_good));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check("reset_dv", int'(rx_dv), 0);
        check("reset_fe", int'(rx_fe), 0);
        check("reset_pe", int'(rx_pe), 0);
        check("reset_byte", int'(rx_byte), 0);
        rst = 1'b0;
        idle(2 * CPB);

        // Single character
        frame(8'h55, 1'b1, 1'b1, 0);
        idle(2 * CPB);
        compare_events("single_55");

        // Back-to-back with exactly one stop bit
        frame(8'hA5, 1'b1, 1'b1, 0);
        frame(8'h3C, 1'b1, 1'b1, 0);
        idle(2 * CPB);
        if (obs_q.size() == 2)
            check("b2b_spacing", obs_q[1].t - obs_q[0].t, BITS_PER_FRAME * CPB);
        compare_events("b2b");

        // Short glitch on an idle line, then a real character
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(3 * CPB);
        frame(8'h81, 1'b1, 1'b1, 0);
        idle(2 * CPB);
        compare_events("glitch");

        // Bad stop bit with the line held low, then recovery
        frame(8'h00, 1'b0, 1'b1, 40);
        idle(CPB);
        frame(8'h7E, 1'b1, 1'b1, 0);
        idle(2 * CPB);
        compare_events("frame_err");

        // Reset during data bit 4 of 0xFF
        begin
            logic [7:0] ff = 8'hFF;
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rx = ff[i];
                repeat (CPB) @(negedge clk);
            end
            rx = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check("midreset_dv", int'(rx_dv), 0);
            check("midreset_fe", int'(rx_fe), 0);
            check("midreset_pe", int'(rx_pe), 0);
            check("midreset_byte", int'(rx_byte), 0);
            rst       = 1'b0;
            last_good = 8'h00;
            idle(6 * CPB);
            frame(8'h81, 1'b1, 1'b1, 0);
            idle(2 * CPB);
            compare_events("midreset");
        end

`ifdef UART_RX_PARITY_EN
        frame(8'h07, 1'b1, 1'b0, 0);
        idle(2 * CPB);
        frame(8'h07, 1'b1, 1'b1, 0);
        idle(2 * CPB);
        compare_events("parity");
`endif

        // Randomized traffic: data, stop/parity faults, gaps and glitches
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            logic       stop_ok;
            logic       par_ok;
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            par_ok  = PARITY_ON ? ($urandom_range(0, 4) != 0) : 1'b1;
            frame(b, stop_ok, par_ok, int'($urandom_range(0, 20)));
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0;
                repeat (int'($urandom_range(1, 2))) @(negedge clk);
                idle(2 * CPB);
            end
            idle(int'($urandom_range(0, 2)) * CPB);
        end
        idle(2 * CPB);
        compare_events("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
